// File: rtl/reduce_stream_arbiter.sv
// Two-requester stream arbiter in front of a shared reduce unit.
// Grants whole streams and routes results back through an owner FIFO.
module reduce_stream_arbiter #(
    parameter int unsigned           DATA_WIDTH  = 17,
    parameter logic [DATA_WIDTH-1:0] DONE_TOKEN  = 17'h10100,
    parameter int unsigned           OWNER_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          flush,
    input  logic                          tile_en,
    input  logic [DATA_WIDTH-1:0]         req0_data,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [DATA_WIDTH-1:0]         req1_data,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    output logic [DATA_WIDTH-1:0]         red_data_in,
    output logic                          red_data_in_valid,
    input  logic                          red_data_in_ready,
    input  logic [DATA_WIDTH-1:0]         red_data_out,
    input  logic                          red_data_out_valid,
    output logic                          red_data_out_ready,
    output logic [DATA_WIDTH-1:0]         out0_data,
    output logic                          out0_valid,
    input  logic                          out0_ready,
    output logic [DATA_WIDTH-1:0]         out1_data,
    output logic                          out1_valid,
    input  logic                          out1_ready,
    output logic                          grant_id,
    output logic                          busy,
    output logic [$clog2(OWNER_DEPTH):0]  owner_count
);

    localparam int unsigned AW = $clog2(OWNER_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(OWNER_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [OWNER_DEPTH-1:0] owner_q, owner_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;

    logic act;
    logic fifo_full;
    logic fifo_empty;
    logic head;
    logic push;
    logic pop;
    logic in_done;
    logic grant_sel;

    // Flush also gates handshakes so nothing transfers on the clearing edge.
    assign act        = clk_en & tile_en & ~flush;
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign head       = owner_q[rd_ptr_q];

    assign grant_id    = last_grant_q;
    assign busy        = (state_q != IDLE);
    assign owner_count = count_q;

    always_comb begin
        red_data_in       = '0;
        red_data_in_valid = 1'b0;
        req0_ready        = 1'b0;
        req1_ready        = 1'b0;
        unique case (state_q)
            LOCK0: begin
                red_data_in       = req0_data;
                red_data_in_valid = act & req0_valid;
                req0_ready        = act & red_data_in_ready;
            end
            LOCK1: begin
                red_data_in       = req1_data;
                red_data_in_valid = act & req1_valid;
                req1_ready        = act & red_data_in_ready;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        out0_data          = red_data_out;
        out1_data          = red_data_out;
        out0_valid         = 1'b0;
        out1_valid         = 1'b0;
        red_data_out_ready = 1'b0;
        if (act && !fifo_empty) begin
            if (head) begin
                out1_valid         = red_data_out_valid;
                red_data_out_ready = out1_ready;
            end else begin
                out0_valid         = red_data_out_valid;
                red_data_out_ready = out0_ready;
            end
        end
    end

    assign in_done = red_data_in_valid & red_data_in_ready
                   & (red_data_in == DONE_TOKEN);
    assign pop     = red_data_out_valid & red_data_out_ready
                   & (red_data_out == DONE_TOKEN);

    // Fullness is judged on the registered count, so a same-cycle pop
    // never lets a grant through.
    assign push      = act & (state_q == IDLE) & ~fifo_full
                     & (req0_valid | req1_valid);
    assign grant_sel = (req0_valid & req1_valid) ? ~last_grant_q
                                                 : req1_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        unique case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = grant_sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (in_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            last_grant_d      = grant_sel;
            owner_d[wr_ptr_q] = grant_sel;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (clk_en && flush) begin
            state_d      = IDLE;
            last_grant_d = 1'b1;
            owner_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_reduce_stream_arbiter.sv
// Directed bench for reduce_stream_arbiter.
// Inputs driven after negedge, outputs sampled 1ns later.
module tb_reduce_stream_arbiter;

    localparam int DW = 17;
    localparam logic [DW-1:0] DONE = 17'h10100;

    logic          clk;
    logic          rst_n;
    logic          clk_en;
    logic          flush;
    logic          tile_en;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] red_data_in;
    logic          red_data_in_valid, red_data_in_ready;
    logic [DW-1:0] red_data_out;
    logic          red_data_out_valid, red_data_out_ready;
    logic [DW-1:0] out0_data, out1_data;
    logic          out0_valid, out1_valid;
    logic          out0_ready, out1_ready;
    logic          grant_id, busy;
    logic [1:0]    owner_count;

    logic [7:0] flags;
    int errors = 0;
    int checks = 0;
    int in_xfers = 0;

    reduce_stream_arbiter dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .flush(flush), .tile_en(tile_en),
        .req0_data(req0_data), .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .red_data_in(red_data_in),
        .red_data_in_valid(red_data_in_valid),
        .red_data_in_ready(red_data_in_ready),
        .red_data_out(red_data_out),
        .red_data_out_valid(red_data_out_valid),
        .red_data_out_ready(red_data_out_ready),
        .out0_data(out0_data), .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .grant_id(grant_id), .busy(busy),
        .owner_count(owner_count)
    );

    // {req0_rdy, req1_rdy, rin_vld, rout_rdy, o0_vld, o1_vld, busy, gid}
    assign flags = {req0_ready, req1_ready, red_data_in_valid,
                    red_data_out_ready, out0_valid, out1_valid,
                    busy, grant_id};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (red_data_in_valid && red_data_in_ready)
            in_xfers <= in_xfers + 1;

    task automatic idle_inputs();
        clk_en = 1'b1; tile_en = 1'b1; flush = 1'b0;
        req0_valid = 1'b0; req0_data = '0;
        req1_valid = 1'b0; req1_data = '0;
        red_data_in_ready = 1'b1;
        red_data_out_valid = 1'b0; red_data_out = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        red_data_out_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
        #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL rst_flags got %h exp %h", flags, 8'h01); end
        checks++; if (owner_count !== 2'd0) begin errors++;
            $display("FAIL rst_count got %0d exp 0", owner_count); end
        @(posedge clk); #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL rst_flags_held got %h exp %h", flags, 8'h01); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_enables();
        do_reset();
        @(negedge clk); req0_valid = 1'b1; req0_data = 17'h5; clk_en = 1'b0; #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL en_clk_off got %h exp %h", flags, 8'h01); end
        @(negedge clk); clk_en = 1'b1; tile_en = 1'b0; #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL en_tile_off got %h exp %h", flags, 8'h01); end
        @(negedge clk); tile_en = 1'b1; #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL en_no_update got %h exp %h", flags, 8'h01); end
        @(negedge clk); #1;
        checks++; if (flags !== 8'hA2) begin errors++;
            $display("FAIL en_grant got %h exp %h", flags, 8'hA2); end
        @(negedge clk); clk_en = 1'b0; #1;
        checks++; if (flags !== 8'h02) begin errors++;
            $display("FAIL en_gate_lock got %h exp %h", flags, 8'h02); end
        @(negedge clk); clk_en = 1'b1;
    endtask

    task automatic test_single_stream();
        int base;
        do_reset();
        base = in_xfers;
        out0_ready = 1'b1;
        @(negedge clk); req0_valid = 1'b1; req0_data = 17'h00003; #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL ss_arb_cycle got %h exp %h", flags, 8'h01); end
        @(negedge clk); #1;
        checks++; if (flags !== 8'hB2) begin errors++;
            $display("FAIL ss_lock got %h exp %h", flags, 8'hB2); end
        checks++; if (owner_count !== 2'd1) begin errors++;
            $display("FAIL ss_count1 got %0d exp 1", owner_count); end
        checks++; if (red_data_in !== 17'h00003) begin errors++;
            $display("FAIL ss_rdata got %h exp %h", red_data_in, 17'h3); end
        @(negedge clk); req0_data = 17'h00004;
        @(negedge clk); req0_data = 17'h10000; #1;
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL ss_ctrl_hold got %b exp 1", busy); end
        @(negedge clk); req0_data = DONE;
        @(negedge clk); req0_valid = 1'b0;
        red_data_out_valid = 1'b1; red_data_out = 17'h00007; #1;
        checks++; if (flags !== 8'h18) begin errors++;
            $display("FAIL ss_idle_out got %h exp %h", flags, 8'h18); end
        checks++; if (out0_data !== 17'h00007) begin errors++;
            $display("FAIL ss_out0_data got %h exp %h", out0_data, 17'h7); end
        checks++; if (in_xfers - base !== 4) begin errors++;
            $display("FAIL ss_xfers got %0d exp 4", in_xfers - base); end
        @(negedge clk); red_data_out = DONE; #1;
        checks++; if (owner_count !== 2'd1) begin errors++;
            $display("FAIL ss_count_hold got %0d exp 1", owner_count); end
        @(negedge clk); red_data_out_valid = 1'b0; #1;
        checks++; if (owner_count !== 2'd0) begin errors++;
            $display("FAIL ss_count_pop got %0d exp 0", owner_count); end
        checks++; if (flags !== 8'h00) begin errors++;
            $display("FAIL ss_final got %h exp %h", flags, 8'h00); end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = DONE;
        req1_valid = 1'b1; req1_data = DONE; #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL ct_idle got %h exp %h", flags, 8'h01); end
        @(negedge clk); #1;
        checks++; if (flags !== 8'hA2) begin errors++;
            $display("FAIL ct_first_req0 got %h exp %h", flags, 8'hA2); end
        @(negedge clk); #1;
        checks++; if (flags !== 8'h00) begin errors++;
            $display("FAIL ct_released got %h exp %h", flags, 8'h00); end
        @(negedge clk); #1;
        checks++; if (flags !== 8'h63) begin errors++;
            $display("FAIL ct_second_req1 got %h exp %h", flags, 8'h63); end
        checks++; if (red_data_in !== DONE) begin errors++;
            $display("FAIL ct_route1 got %h exp %h", red_data_in, DONE); end
        @(negedge clk); #1;
        checks++; if (owner_count !== 2'd2 || flags !== 8'h01) begin
            errors++;
            $display("FAIL ct_full got cnt=%0d flags=%h exp cnt=2 flags=01",
                     owner_count, flags);
        end
        @(negedge clk);
        red_data_out_valid = 1'b1; red_data_out = DONE;
        out0_ready = 1'b1; out1_ready = 1'b1; #1;
        checks++; if (flags !== 8'h19) begin errors++;
            $display("FAIL ct_pop_full got %h exp %h", flags, 8'h19); end
        @(negedge clk); red_data_out_valid = 1'b0; #1;
        checks++; if (flags !== 8'h11 || owner_count !== 2'd1) begin
            errors++;
            $display("FAIL ct_no_grant_on_pop got flags=%h cnt=%0d exp 11/1",
                     flags, owner_count);
        end
        @(negedge clk); #1;
        checks++; if (flags !== 8'hB2) begin errors++;
            $display("FAIL ct_third_req0 got %h exp %h", flags, 8'hB2); end
    endtask

    task automatic test_overlap();
        do_reset();
        @(negedge clk); req0_valid = 1'b1; req0_data = 17'h00011;
        @(negedge clk);
        @(negedge clk); req0_data = DONE;
        @(negedge clk); req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 17'h00022;
        @(negedge clk); #1;
        checks++; if (flags !== 8'h63 || owner_count !== 2'd2) begin
            errors++;
            $display("FAIL ov_lock1 got flags=%h cnt=%0d exp 63/2",
                     flags, owner_count);
        end
        @(negedge clk); req1_data = DONE;
        @(negedge clk); req1_valid = 1'b0;
        req0_valid = 1'b1; req0_data = 17'h00033; #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL ov_full_idle got %h exp %h", flags, 8'h01); end
        @(negedge clk);
        red_data_out_valid = 1'b1; red_data_out = 17'h00055;
        out0_ready = 1'b1; out1_ready = 1'b1; #1;
        checks++; if (flags !== 8'h19) begin errors++;
            $display("FAIL ov_out0_first got %h exp %h", flags, 8'h19); end
        checks++; if (out0_data !== 17'h00055) begin errors++;
            $display("FAIL ov_out0_data got %h exp %h", out0_data, 17'h55); end
        @(negedge clk); red_data_out = DONE; #1;
        checks++; if (flags !== 8'h19) begin errors++;
            $display("FAIL ov_out0_done got %h exp %h", flags, 8'h19); end
        @(negedge clk); red_data_out = 17'h00066; #1;
        checks++; if (flags !== 8'h15 || owner_count !== 2'd1) begin
            errors++;
            $display("FAIL ov_out1_next got flags=%h cnt=%0d exp 15/1",
                     flags, owner_count);
        end
        @(negedge clk); red_data_out = DONE; #1;
        checks++; if (flags !== 8'hB6 || owner_count !== 2'd2) begin
            errors++;
            $display("FAIL ov_regrant got flags=%h cnt=%0d exp B6/2",
                     flags, owner_count);
        end
        checks++; if (red_data_in !== 17'h00033) begin errors++;
            $display("FAIL ov_rdata got %h exp %h", red_data_in, 17'h33); end
        @(negedge clk); red_data_out_valid = 1'b0; #1;
        checks++; if (owner_count !== 2'd1) begin errors++;
            $display("FAIL ov_pushpop got %0d exp 1", owner_count); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] toks [5];
        logic [DW-1:0] got [$];
        int idx;
        int bad_rdy;
        int bad_data;
        int base;
        toks = '{17'h00101, 17'h00102, 17'h10001, 17'h00103, DONE};
        do_reset();
        base = in_xfers;
        idx = 0; bad_rdy = 0; bad_data = 0;
        red_data_out_valid = 1'b1; red_data_out = 17'h0002A;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            red_data_in_ready = 1'($urandom_range(0, 1));
            if (cyc == 20) begin
                out1_ready = 1'b1; red_data_out_valid = 1'b0;
            end
            req1_valid = (idx < 5);
            req1_data = (idx < 5) ? toks[idx] : '0;
            #1;
            if (cyc < 20 && red_data_out_ready) bad_rdy++;
            if (cyc == 10) begin
                checks++; if (out1_valid !== 1'b1 || out0_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_route got o0=%b o1=%b exp o0=0 o1=1",
                             out0_valid, out1_valid);
                end
            end
            if (req1_valid && req1_ready) begin
                got.push_back(red_data_in);
                idx++;
            end
            if (idx == 5 && cyc >= 20) break;
        end
        @(negedge clk); req1_valid = 1'b0; red_data_in_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (idx !== 5) begin errors++;
            $display("FAIL bp_timeout got %0d tokens exp 5", idx); end
        for (int i = 0; i < got.size() && i < 5; i++)
            if (got[i] !== toks[i]) bad_data++;
        checks++; if (bad_data !== 0 || got.size() !== 5) begin errors++;
            $display("FAIL bp_stream got %0d bad of %0d exp 0 of 5",
                     bad_data, got.size());
        end
        checks++; if (in_xfers - base !== 5) begin errors++;
            $display("FAIL bp_xfers got %0d exp 5", in_xfers - base); end
        checks++; if (bad_rdy !== 0) begin errors++;
            $display("FAIL bp_out_ready got %0d cycles exp 0", bad_rdy); end
        checks++; if (owner_count !== 2'd1 || busy !== 1'b0) begin errors++;
            $display("FAIL bp_final got cnt=%0d busy=%b exp 1/0",
                     owner_count, busy);
        end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk); req0_valid = 1'b1; req0_data = 17'h00005;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        checks++; if (flags !== 8'h01 || owner_count !== 2'd0) begin
            errors++;
            $display("FAIL fl_cleared got flags=%h cnt=%0d exp 01/0",
                     flags, owner_count);
        end
        @(negedge clk); #1;
        checks++; if (flags !== 8'hA2) begin errors++;
            $display("FAIL fl_regrant got %h exp %h", flags, 8'hA2); end
    endtask

    task automatic test_async_reset();
        int base;
        do_reset();
        @(negedge clk); req0_valid = 1'b1; req0_data = 17'h00007;
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        base = in_xfers;
        checks++; if (flags !== 8'h01 || owner_count !== 2'd0) begin
            errors++;
            $display("FAIL ar_immediate got flags=%h cnt=%0d exp 01/0",
                     flags, owner_count);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (flags !== 8'h01) begin errors++;
            $display("FAIL ar_after got %h exp %h", flags, 8'h01); end
        checks++; if (in_xfers - base !== 0) begin errors++;
            $display("FAIL ar_no_xfer got %0d exp 0", in_xfers - base); end
        @(negedge clk); #1;
        checks++; if (flags !== 8'hA2) begin errors++;
            $display("FAIL ar_regrant got %h exp %h", flags, 8'hA2); end
    endtask

    initial begin
        test_reset();
        test_enables();
        test_single_stream();
        test_contention();
        test_overlap();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
